// File: rtl/freq_counter_master.sv
// freq_counter_master: Wishbone initiator that runs one measurement on the
// frequency counter. The sequence is clear, arm, poll for done, read the
// coarse and fine results, then disarm.
// Ports: clk_i and ext_rst_i (synchronous, active-low).
//   start_i -> busy_o, done_o, status_o, coarse_o, fine_o (user side).
//   adr_o, dat_o, we_o, sel_o, cyc_o, stb_o and dat_i, ack_i, err_i, rty_i
//   form the Wishbone master port.
module freq_counter_master #(
    parameter int POLL_GAP    = 64,
    parameter int MAX_POLLS   = 1024,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        ext_rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  status_o,
    output logic [31:0] coarse_o,
    output logic [7:0]  fine_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = $clog2(POLL_GAP + 1);
    localparam int PW = $clog2(MAX_POLLS + 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CLR    = 4'd1;
    localparam logic [3:0] S_ARM    = 4'd2;
    localparam logic [3:0] S_GAP    = 4'd3;
    localparam logic [3:0] S_POLL   = 4'd4;
    localparam logic [3:0] S_RDC    = 4'd5;
    localparam logic [3:0] S_RDF    = 4'd6;
    localparam logic [3:0] S_DISARM = 4'd7;
    localparam logic [3:0] S_FIN    = 4'd8;
    localparam logic [3:0] S_ABORT  = 4'd9;

    // Phases of a transfer state: strobing, one idle cycle, then decode.
    localparam logic [1:0] PH_ACT = 2'd0;
    localparam logic [1:0] PH_IDL = 2'd1;
    localparam logic [1:0] PH_DEC = 2'd2;

    // Transfer results share their encoding with status_o.
    localparam logic [1:0] RES_OK  = 2'b00;
    localparam logic [1:0] RES_ERR = 2'b01;
    localparam logic [1:0] RES_TMO = 2'b10;
    localparam logic [1:0] RES_MTO = 2'b11;

    logic [3:0]    r_state;
    logic [1:0]    r_ph;
    logic [1:0]    r_res;
    logic          r_dn;
    logic [TW-1:0] r_tcnt;
    logic [GW-1:0] r_gcnt;
    logic [PW-1:0] r_polls;
    logic          r_cyc;
    logic [31:0]   r_adr;
    logic [31:0]   r_dat;
    logic          r_we;
    logic [3:0]    r_sel;
    logic          r_busy;
    logic          r_done;
    logic [1:0]    r_status;
    logic [31:0]   r_coarse;
    logic [7:0]    r_fine;

    logic          w_xfer;
    logic          w_term;
    logic          w_bad;
    logic          w_tmo;
    logic          w_end;
    logic          w_gap_end;
    logic [3:0]    w_nxt;
    logic [1:0]    w_nst;
    logic          w_go;
    logic [3:0]    w_tgt;
    logic [64:0]   w_bus;

    // {we, adr, dat} for the access issued by each transfer state.
    function automatic logic [64:0] f_bus(input logic [3:0] s);
        logic [64:0] v;
        v = '0;
        case (s)
            S_CLR:    v = {1'b1, 32'h08, 32'h01};
            S_ABORT:  v = {1'b1, 32'h08, 32'h01};
            S_ARM:    v = {1'b1, 32'h08, 32'h80};
            S_POLL:   v = {1'b0, 32'h08, 32'h00};
            S_RDC:    v = {1'b0, 32'h09, 32'h00};
            S_RDF:    v = {1'b0, 32'h0a, 32'h00};
            S_DISARM: v = {1'b1, 32'h08, 32'h00};
            default:  v = '0;
        endcase
        return v;
    endfunction

    assign w_xfer = (r_state != S_IDLE) && (r_state != S_GAP) &&
                    (r_state != S_FIN);
    // The slave ack is registered and may still be high from the
    // previous access, so terminations in the first stb cycle are ignored.
    assign w_term = (r_tcnt != '0) && (ack_i || err_i || rty_i);
    assign w_bad  = err_i || rty_i;
    assign w_tmo  = !w_term && (r_tcnt == TW'(ACK_TIMEOUT - 1));
    assign w_end  = w_term || w_tmo;
    assign w_gap_end = (r_gcnt == GW'(POLL_GAP - 1));

    always_comb begin
        w_nxt = S_FIN;
        w_nst = r_status;
        if (r_state == S_ABORT) begin
            w_nxt = S_FIN;
        end else if (r_res != RES_OK) begin
            w_nxt = S_ABORT;
            w_nst = r_res;
        end else begin
            case (r_state)
                S_CLR:  w_nxt = S_ARM;
                S_ARM:  w_nxt = S_GAP;
                S_POLL: begin
                    if (r_dn) begin
                        w_nxt = S_RDC;
                    end else if (r_polls == PW'(MAX_POLLS)) begin
                        w_nxt = S_ABORT;
                        w_nst = RES_MTO;
                    end else begin
                        w_nxt = S_GAP;
                    end
                end
                S_RDC:  w_nxt = S_RDF;
                S_RDF:  w_nxt = S_DISARM;
                default: w_nxt = S_FIN;
            endcase
        end
    end

    always_comb begin
        w_go  = 1'b0;
        w_tgt = w_nxt;
        if (r_state == S_IDLE) begin
            w_go  = start_i;
            w_tgt = S_CLR;
        end else if (r_state == S_GAP) begin
            w_go  = w_gap_end;
            w_tgt = S_POLL;
        end else if (w_xfer && r_ph == PH_DEC) begin
            w_go  = (w_nxt != S_GAP) && (w_nxt != S_FIN);
        end
        w_bus = f_bus(w_tgt);
    end

    always_ff @(posedge clk_i) begin
        if (!ext_rst_i) begin
            r_state  <= S_IDLE;
            r_ph     <= PH_ACT;
            r_res    <= RES_OK;
            r_dn     <= 1'b0;
            r_tcnt   <= '0;
            r_gcnt   <= '0;
            r_polls  <= '0;
            r_cyc    <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_status <= RES_OK;
            r_coarse <= '0;
            r_fine   <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE && start_i) begin
                r_busy   <= 1'b1;
                r_status <= RES_OK;
                r_polls  <= '0;
                r_state  <= S_CLR;
            end
            if (r_state == S_GAP) begin
                if (w_gap_end) begin
                    r_gcnt  <= '0;
                    r_polls <= r_polls + 1'b1;
                    r_state <= S_POLL;
                end else begin
                    r_gcnt <= r_gcnt + 1'b1;
                end
            end
            if (r_state == S_FIN) begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
            end
            if (w_xfer) begin
                case (r_ph)
                    PH_ACT: begin
                        if (w_end) begin
                            r_cyc  <= 1'b0;
                            r_ph   <= PH_IDL;
                            r_tcnt <= '0;
                            r_res  <= w_tmo ? RES_TMO :
                                      (w_bad ? RES_ERR : RES_OK);
                            if (w_term && !w_bad) begin
                                if (r_state == S_POLL) r_dn <= dat_i[6];
                                if (r_state == S_RDC) r_coarse <= dat_i;
                                if (r_state == S_RDF) r_fine <= dat_i[7:0];
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                    PH_IDL: r_ph <= PH_DEC;
                    default: begin
                        r_state  <= w_nxt;
                        r_status <= w_nst;
                        r_done   <= (w_nxt == S_FIN);
                        if (w_nxt == S_GAP) r_gcnt <= '0;
                    end
                endcase
            end
            if (w_go) begin
                r_cyc  <= 1'b1;
                r_ph   <= PH_ACT;
                r_tcnt <= '0;
                r_sel  <= 4'hF;
                {r_we, r_adr, r_dat} <= w_bus;
            end
        end
    end

    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign status_o = r_status;
    assign coarse_o = r_coarse;
    assign fine_o   = r_fine;
    assign adr_o    = r_adr;
    assign dat_o    = r_dat;
    assign we_o     = r_we;
    assign sel_o    = r_sel;
    assign cyc_o    = r_cyc;
    assign stb_o    = r_cyc;

endmodule
